// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit. Dispatch allocates entries at the tail,
// functional units mark entries done out of order, and the oldest done entry
// retires each cycle as registered free-register / flag-write pulses.
module rob_commit #(
  parameter int unsigned NUM_PHYS_REG = 64,
  parameter int unsigned NUM_FU       = 2,
  parameter int unsigned NUM_FLAGS    = 4,
  parameter int unsigned ROB_DEPTH    = 16,
  parameter int unsigned TAG_W        = $clog2(ROB_DEPTH),
  parameter int unsigned PHYS_W       = $clog2(NUM_PHYS_REG)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        disp_v_i,
  output logic                        disp_ready_o,
  output logic [TAG_W-1:0]            disp_tag_o,
  input  logic                        disp_old_phys_v_i,
  input  logic [PHYS_W-1:0]           disp_old_phys_i,
  input  logic [NUM_FLAGS-1:0]        disp_flag_mask_i,
  input  logic [NUM_FU-1:0]           fu_done_v_i,
  input  logic [NUM_FU*TAG_W-1:0]     fu_done_tag_i,
  input  logic [NUM_FU*NUM_FLAGS-1:0] fu_done_flag_i,
  output logic                        rob_phys_valid_o,
  output logic [PHYS_W-1:0]           rob_phys_reg_cl_o,
  output logic                        rob_flag_valid_o,
  output logic [2*NUM_FLAGS-1:0]      rob_flag_o,
  output logic                        commit_v_o,
  output logic [TAG_W-1:0]            commit_tag_o,
  output logic [TAG_W:0]              rob_count_o
);

  localparam logic [TAG_W:0] DepthCnt = (TAG_W + 1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] old_phys_v_q;
  logic [PHYS_W-1:0]    old_phys_q  [ROB_DEPTH];
  logic [NUM_FLAGS-1:0] flag_mask_q [ROB_DEPTH];
  logic [NUM_FLAGS-1:0] flag_val_q  [ROB_DEPTH];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q;

  logic [TAG_W-1:0]     fu_tag  [NUM_FU];
  logic [NUM_FLAGS-1:0] fu_flag [NUM_FU];

  logic disp_accept;
  logic retire;

  // Unpack the flattened per-FU completion buses.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_tag[f]  = fu_done_tag_i[f*TAG_W +: TAG_W];
      fu_flag[f] = fu_done_flag_i[f*NUM_FLAGS +: NUM_FLAGS];
    end
  end

  // Readiness depends on registered count only, so a full ROB stays blocked
  // even in a cycle where the head retires.
  assign disp_ready_o = (count_q < DepthCnt);
  assign disp_tag_o   = tail_q;
  assign rob_count_o  = count_q;
  assign disp_accept  = disp_v_i && disp_ready_o && !flush_i;
  assign retire       = valid_q[head_q] && done_q[head_q] && !flush_i;

  // Entry storage: allocate, complete (higher FU index wins), and retire.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q      <= '0;
      done_q       <= '0;
      old_phys_v_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        old_phys_q[i]  <= '0;
        flag_mask_q[i] <= '0;
        flag_val_q[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (disp_accept) begin
        valid_q[tail_q]      <= 1'b1;
        done_q[tail_q]       <= 1'b0;
        old_phys_v_q[tail_q] <= disp_old_phys_v_i;
        old_phys_q[tail_q]   <= disp_old_phys_i;
        flag_mask_q[tail_q]  <= disp_flag_mask_i;
        flag_val_q[tail_q]   <= '0;
      end
      // Later iterations override earlier ones for a shared tag.
      for (int f = 0; f < NUM_FU; f++) begin
        if (fu_done_v_i[f] && valid_q[fu_tag[f]]) begin
          done_q[fu_tag[f]]     <= 1'b1;
          flag_val_q[fu_tag[f]] <= fu_flag[f];
        end
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  // Head/tail pointers wrap naturally at ROB_DEPTH; count tracks occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (disp_accept) tail_q <= tail_q + 1'b1;
      if (retire)      head_q <= head_q + 1'b1;
      unique case ({disp_accept, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered commit outputs: pulses for one cycle, data holds otherwise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      commit_v_o        <= 1'b0;
      commit_tag_o      <= '0;
      rob_phys_valid_o  <= 1'b0;
      rob_phys_reg_cl_o <= '0;
      rob_flag_valid_o  <= 1'b0;
      rob_flag_o        <= '0;
    end else if (retire) begin
      commit_v_o        <= 1'b1;
      commit_tag_o      <= head_q;
      rob_phys_valid_o  <= old_phys_v_q[head_q];
      rob_phys_reg_cl_o <= old_phys_q[head_q];
      rob_flag_valid_o  <= |flag_mask_q[head_q];
      rob_flag_o        <= {flag_mask_q[head_q], flag_val_q[head_q] & flag_mask_q[head_q]};
    end else begin
      commit_v_o       <= 1'b0;
      rob_phys_valid_o <= 1'b0;
      rob_flag_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit unit: the producer side of the physical-register clear and flag-write interfaces consumed by the architectural state block. Dispatch allocates entries in program order and functional units mark them complete out of order. The oldest completed entry retires once per cycle. Retirement frees the superseded physical register and applies the masked flag update as single-cycle registered pulses.

## Interface
Parameters (widths NUM_PHYS_REG, NUM_FU, NUM_FLAGS come from Purple_Jade_pkg):
- ROB_DEPTH, 16, number of entries; must be a power of two, ≥ 2
- TAG_W, $clog2(ROB_DEPTH), entry tag width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous discard of every entry
- disp_v_i  in  1  dispatch request
- disp_ready_o  out  1  entry available (count < ROB_DEPTH)
- disp_tag_o  out  TAG_W  tag assigned to the current dispatch (tail pointer)
- disp_old_phys_v_i  in  1  instruction has a destination that supersedes a mapping
- disp_old_phys_i  in  $clog2(NUM_PHYS_REG)  superseded physical register to free at commit
- disp_flag_mask_i  in  NUM_FLAGS  flags written by the instruction
- fu_done_v_i  in  NUM_FU  completion strobe per functional unit
- fu_done_tag_i  in  NUM_FU×TAG_W  tag completing
- fu_done_flag_i  in  NUM_FU×NUM_FLAGS  flag values produced
- rob_phys_valid_o  out  1  free-register pulse
- rob_phys_reg_cl_o  out  $clog2(NUM_PHYS_REG)  register to clear
- rob_flag_valid_o  out  1  flag-write pulse
- rob_flag_o  out  2×NUM_FLAGS  {mask, values}; mask in the upper half
- commit_v_o  out  1  an entry retired
- commit_tag_o  out  TAG_W  tag of the retired entry
- rob_count_o  out  TAG_W+1  occupied entries

## Operation
- Per-entry state: valid, done, old_phys_v, old_phys, flag_mask, flag_val.
- Pointers: head and tail (TAG_W bits, wrap modulo ROB_DEPTH) plus a count register.
- Dispatch accepted when disp_v_i && disp_ready_o && !flush_i.
  - The entry at tail is written: valid=1, done=0, flag_val=0.
  - tail increments.
  - disp_v_i while not ready is ignored; the source holds the request.
- Completion: for each i with fu_done_v_i[i], when the addressed entry is valid, set done=1 and flag_val = fu_done_flag_i[i].
  - Completion to an invalid entry is ignored.
  - When two FUs name the same tag, the higher FU index supplies flag_val.
- Retire: when head is valid && done && !flush_i:
  - clear the entry's valid bit and increment head;
  - load the output registers: commit_v_o=1, commit_tag_o=head, rob_phys_valid_o=old_phys_v, rob_phys_reg_cl_o=old_phys, rob_flag_valid_o=(flag_mask≠0), rob_flag_o={flag_mask, flag_val & flag_mask}.
  - Otherwise every *_valid_o and commit_v_o is 0 the next cycle; the data outputs hold their last values.
- Count: +1 on accepted dispatch, −1 on retire, unchanged when both occur in the same cycle.
- Flush: all valid bits clear, head=tail=0, count=0. The output pulses are 0 the next cycle; in-flight completions that cycle are dropped.

## Timing
- Reset (asynchronous): all entries invalid, head=tail=count=0, and every output register is 0. Hence rob_phys_valid_o=0, rob_flag_valid_o=0, commit_v_o=0, rob_phys_reg_cl_o=0, rob_flag_o=0 and commit_tag_o=0.
- Combinational outputs under reset: disp_tag_o=0, disp_ready_o=1, rob_count_o=0.
- Reset asserted mid-operation discards all state immediately; no pulse is emitted.
- disp_ready_o and disp_tag_o are combinational from the registers only.
  - A full ROB blocks dispatch even when a retire happens in the same cycle.
- Latency:
  - dispatch at edge N;
  - completion sampled at edge ≥ N+1;
  - retire at the following edge (the done bit must be registered first);
  - output pulses are visible for exactly one cycle after the retire edge.
- Throughput: one retire per cycle; back-to-back retires give contiguous pulses.
- Completion of an entry at the same edge it is dispatched is not permitted.
- Wrap-around: the pointers roll from ROB_DEPTH−1 to 0 with no gap.

## Test plan
- Reset then idle: disp_ready_o=1, rob_count_o=0, all pulses 0 for 10 cycles.
- Dispatch tags 0,1,2 (old_phys 20,21,22, mask 0); complete order 2,0,1:
  - commit pulses for tags 0,1,2 on consecutive cycles;
  - rob_phys_reg_cl_o=20,21,22;
  - no rob_flag_valid_o.
- Fill 16 entries: disp_ready_o=0 and count=16.
  - Complete tag 0: one retire, then ready=1.
  - Dispatch the 17th: it gets tag 0 (wrap) and count stays 16.
- Dispatch with mask 4'b0011; FU0 and FU1 complete the same tag with 4'b1111 and 4'b0110: rob_flag_o={4'b0011, 4'b0010}, flag_valid=1.
- Dispatch with disp_old_phys_v_i=0: commit_v_o=1, rob_phys_valid_o=0.
- Flush with 5 entries, 2 of them done:
  - no pulses follow, count=0, next dispatch gets tag 0;
  - asserting reset_i mid-retire clears the pulse asynchronously.
